neural_sample_player: RTL

//  Synthesizable multi-channel sample source for the neural pipeline.

---
 rtl/neural_pipeline_pkg.sv | 22 ++
 rtl/neural_rate_tick.sv | 42 ++++
 rtl/neural_sample_player.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/neural_pipeline_pkg.sv
// Shared state encoding, default sample width and index-width helper
// for the neural pipeline blocks.
package neural_pipeline_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_EMIT      = 2'd2
  } player_state_e;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/neural_rate_tick.sv
// Free-running rate generator: one-cycle tick every DIV clocks, restartable
// through a synchronous clear.
module neural_rate_tick
  import neural_pipeline_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TW = idx_w(DIV);
  localparam logic [TW-1:0] TOP = TW'(DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: wrap at DIV-1, or restart on clear.
  always_comb begin
    if (clr) begin
      cnt_d = TW'(0);
    end else if (cnt_q == TOP) begin
      cnt_d = TW'(0);
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= TW'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TOP);

endmodule

// File: rtl/neural_sample_player.sv
// Replays channel-interleaved recorded samples from on-chip memory, one frame
// per rate tick, as a valid/ready stream into the neural pipeline.
module neural_sample_player
  import neural_pipeline_pkg::*;
#(
  parameter int unsigned DATA_W     = SAMPLE_W,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DIV        = 33333,
  parameter int unsigned MAX_FRAMES = 1600000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       mode_loop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [idx_w(CHANNELS)-1:0] out_chan,
  output logic                       out_frame_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic [31:0]                sample_count
);

  localparam int unsigned CW = idx_w(CHANNELS);
  localparam int unsigned MW = idx_w(DEPTH);
  localparam int unsigned AW = idx_w(DEPTH + 1);
  localparam int unsigned FW = idx_w(MAX_FRAMES + 1);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [FW-1:0] MAX_F     = FW'(MAX_FRAMES);

  player_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] length_q, length_d;
  logic [CW-1:0] load_chan_q, load_chan_d;
  logic [AW-1:0] load_base_q, load_base_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          loop_q, loop_d;
  logic          stop_pend_q, stop_pend_d;
  logic          load_ready_q, load_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic          out_frame_last_q, out_frame_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   sample_count_q, sample_count_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          tick_s;
  logic          tick_clr_s;
  logic          load_hs_s;
  logic          out_hs_s;
  logic          stop_now_s;
  logic          load_full_s;
  logic          data_end_s;
  logic [AW-1:0] wr_nxt_s;
  logic [AW-1:0] rd_nxt_s;
  logic [AW-1:0] base_nxt_s;
  logic [FW-1:0] frame_nxt_s;
  logic [MW-1:0] rd_addr_s;
  logic [MW-1:0] wr_addr_s;

  // The divider is held at zero while idle so every start begins a full period.
  assign tick_clr_s = (state_q == ST_IDLE);

  neural_rate_tick #(.DIV(DIV)) u_rate_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr_s),
    .tick (tick_s)
  );

  assign load_hs_s   = rst && load_valid && load_ready_q;
  assign out_hs_s    = out_valid_q && out_ready;
  assign stop_now_s  = stop || stop_pend_q;
  assign wr_nxt_s    = wr_ptr_q + AW'(1);
  assign rd_nxt_s    = rd_ptr_q + AW'(1);
  assign load_full_s = (load_chan_q == LAST_CHAN);
  assign base_nxt_s  = load_full_s ? wr_nxt_s : load_base_q;
  assign frame_nxt_s = frame_cnt_q + FW'(1);
  assign data_end_s  = (rd_nxt_s == length_q);
  assign wr_addr_s   = wr_ptr_q[MW-1:0];
  // Reading at the next pointer keeps rd_data_q equal to mem[rd_ptr_q] every cycle.
  assign rd_addr_s   = rd_ptr_d[MW-1:0];

  // Next-state logic for the load path, the playback FSM and all registered outputs.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    length_d       = length_q;
    load_chan_d    = load_chan_q;
    load_base_d    = load_base_q;
    frame_cnt_d    = frame_cnt_q;
    loop_d         = loop_q;
    stop_pend_d    = stop_pend_q;
    out_valid_d    = out_valid_q;
    out_chan_d     = out_chan_q;
    overrun_d      = overrun_q;
    sample_count_d = sample_count_q;
    done_d         = 1'b0;

    // load_base tracks the last complete-frame boundary, so a commit drops any partial frame.
    // A commit on a full memory keeps wr_ptr at DEPTH, blocking loads until the next start.
    if (load_hs_s) begin
      if (load_last || (wr_nxt_s == DEPTH_A)) begin
        length_d    = base_nxt_s;
        load_chan_d = CW'(0);
        load_base_d = AW'(0);
        wr_ptr_d    = load_last ? AW'(0) : wr_nxt_s;
      end else begin
        load_chan_d = load_full_s ? CW'(0) : (load_chan_q + CW'(1));
        load_base_d = base_nxt_s;
        wr_ptr_d    = wr_nxt_s;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start && (length_q != AW'(0))) begin
          state_d        = ST_WAIT_TICK;
          rd_ptr_d       = AW'(0);
          frame_cnt_d    = FW'(0);
          sample_count_d = 32'd0;
          overrun_d      = 1'b0;
          loop_d         = mode_loop;
          out_chan_d     = CW'(0);
          wr_ptr_d       = AW'(0);
          load_chan_d    = CW'(0);
          load_base_d    = AW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tick_s) begin
          state_d     = ST_EMIT;
          out_valid_d = 1'b1;
          out_chan_d  = CW'(0);
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_EMIT: begin
        if (tick_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (out_hs_s) begin
          sample_count_d = sample_count_q + 32'd1;
          rd_ptr_d       = data_end_s ? AW'(0) : rd_nxt_s;
          stop_pend_d    = 1'b0;
          if (out_chan_q == LAST_CHAN) begin
            frame_cnt_d = frame_nxt_s;
            out_chan_d  = CW'(0);
            out_valid_d = 1'b0;
            if (stop_now_s || (frame_nxt_s == MAX_F) || (data_end_s && !loop_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_TICK;
            end
          end else if (stop_now_s) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_chan_d  = CW'(0);
          end else begin
            state_d    = ST_EMIT;
            out_chan_d = out_chan_q + CW'(1);
          end
        end else begin
          stop_pend_d = stop_now_s;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        stop_pend_d = 1'b0;
      end
    endcase

    out_frame_last_d = out_valid_d && (out_chan_d == LAST_CHAN);
    busy_d           = (state_d != ST_IDLE);
    load_ready_d     = (state_d == ST_IDLE) && (wr_ptr_d < DEPTH_A);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      wr_ptr_q         <= AW'(0);
      rd_ptr_q         <= AW'(0);
      length_q         <= AW'(0);
      load_chan_q      <= CW'(0);
      load_base_q      <= AW'(0);
      frame_cnt_q      <= FW'(0);
      loop_q           <= 1'b0;
      stop_pend_q      <= 1'b0;
      load_ready_q     <= 1'b0;
      out_valid_q      <= 1'b0;
      out_chan_q       <= CW'(0);
      out_frame_last_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overrun_q        <= 1'b0;
      sample_count_q   <= 32'd0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      length_q         <= length_d;
      load_chan_q      <= load_chan_d;
      load_base_q      <= load_base_d;
      frame_cnt_q      <= frame_cnt_d;
      loop_q           <= loop_d;
      stop_pend_q      <= stop_pend_d;
      load_ready_q     <= load_ready_d;
      out_valid_q      <= out_valid_d;
      out_chan_q       <= out_chan_d;
      out_frame_last_q <= out_frame_last_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      overrun_q        <= overrun_d;
      sample_count_q   <= sample_count_d;
    end
  end

  // Sample memory write port, fed by the load stream.
  always_ff @(posedge clk) begin
    if (load_hs_s) begin
      mem[wr_addr_s] <= load_data;
    end
  end

  // Registered read port; doubles as the out_data register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= mem[rd_addr_s];
    end
  end

  assign load_ready     = load_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = rd_data_q;
  assign out_chan       = out_chan_q;
  assign out_frame_last = out_frame_last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overrun        = overrun_q;
  assign sample_count   = sample_count_q;

endmodule
